rvb_zbb32_issue: RTL and testbench
==================================

RVB_ZBB32_ISSUE -- requirements
Module: rvb_zbb32_issue

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum ISSUE-state cycles without a unit handshake before the op is aborted.
REQ-002 clock  in  1  positive-edge clock; the only clock.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1 / req_ready  out  1  core-side request handshake.
REQ-005 req_insn  in  32 / req_rs1  in  32 / req_rs2  in  32  instruction word and operand values.
REQ-006 fu_valid  out  1 / fu_ready  in  1  drive and sample the Zbb unit's din_valid / din_ready.
REQ-007 fu_decoded  in  1  unit's din_decoded indication for the presented instruction.
REQ-008 fu_insn  out  32 / fu_rs1  out  32 / fu_rs2  out  32  registered instruction and operands presented to the unit.
REQ-009 fu_dout_valid  in  1 / fu_dout_ready  out  1 / fu_rd  in  32  unit result handshake and value.
REQ-010 wb_valid  out  1 / wb_ready  in  1  writeback handshake.
REQ-011 wb_addr  out  5 / wb_data  out  32  destination register (insn[11:7]) and result.
REQ-012 wb_illegal  out  1 / wb_timeout  out  1  status flags qualified by wb_valid.
REQ-013 cnt_clear  in  1 / cnt_ops  out  16 / cnt_err  out  16  counter clear and performance counters.

Function
REQ-014 The block SHALL implement three states: IDLE, ISSUE, RESP.
REQ-015 IDLE: req_ready=1; on req_valid the block SHALL latch insn/rs1/rs2 into fu_* registers, clear the timeout counter and enter ISSUE.
REQ-016 ISSUE: fu_valid=1 and fu_dout_ready=1; all other states SHALL hold both at 0.
REQ-017 ISSUE with fu_decoded=0 SHALL abort in that cycle: wb_data=0, wb_illegal=1, no fu handshake required; next state RESP.
REQ-018 ISSUE with fu_decoded=1 and fu_ready && fu_dout_valid SHALL capture fu_rd into wb_data, set both flags to 0, and enter RESP.
REQ-019 ISSUE without a handshake SHALL increment the timeout counter; on reaching TIMEOUT, the block SHALL set wb_timeout=1 and wb_data=0 and enter RESP.
REQ-020 If wb_addr==0, the block SHALL force wb_data to 0; wb_valid still asserts.
REQ-021 RESP: wb_valid=1; wb_addr, wb_data and flags SHALL stay stable until wb_ready.
REQ-022 RESP: req_ready SHALL equal wb_ready. On wb_ready && req_valid the block SHALL latch the new request and go directly to ISSUE; on wb_ready alone, to IDLE.
REQ-023 Latency: request accepted at edge N, ISSUE during cycle N+1, wb_valid from cycle N+2 when the unit is ready. Sustained throughput is one op per 2 cycles.
REQ-024 fu_* registers SHALL hold their value outside ISSUE; they change only on request acceptance.
REQ-025 cnt_ops SHALL increment by 1 on each wb handshake with both flags 0. cnt_err SHALL increment on each wb handshake with either flag set.
REQ-026 Both counters SHALL saturate at 16'hFFFF.
REQ-027 cnt_clear SHALL zero both counters synchronously and take priority over a same-cycle increment.
REQ-028 Inputs SHALL be ignored while no handshake is enabled: req_* outside req_ready, fu_rd/fu_dout_valid outside ISSUE, wb_ready outside RESP.

Reset
REQ-029 resetn=0 SHALL immediately force state=IDLE and reset all outputs: req_ready=0 while in reset, fu_valid=0, fu_dout_ready=0, wb_valid=0, flags=0, wb_data=0, fu_*=0, counters=0.
REQ-030 The first cycle after deassertion SHALL show req_ready=1.
REQ-031 Reset asserted mid-ISSUE or mid-RESP SHALL discard the in-flight op without a writeback.

Verification
REQ-032 ANDN: req_insn=32'h4020F1B3, rs1=32'hFF00FF00, rs2=32'h0F0F0F0F, unit always ready -> wb_valid at N+2, wb_addr=3, wb_data=32'hF000F000, flags 0, cnt_ops=1.
REQ-033 Illegal: req_insn=32'h00000013 with fu_decoded=0 -> one ISSUE cycle, then wb_illegal=1, wb_data=0, cnt_err=1, cnt_ops unchanged.
REQ-034 Timeout: fu_ready held 0 with TIMEOUT=16 -> exactly 16 ISSUE cycles, then wb_timeout=1, wb_data=0.
REQ-035 Backpressure and back-to-back: wb_ready=0 for 5 cycles -> wb_* stable and req_ready=0. Then wb_ready=1 with a pending req_valid -> ISSUE on the next cycle with no IDLE bubble.
REQ-036 Async reset pulse of 3 ns during ISSUE -> all outputs zero before the next edge, no wb_valid, and counters and cnt_clear-vs-increment checked after reset with cnt_clear winning.

Source files
------------

// File: rtl/rvb_zbb32_issue.sv
// Issue stage between a core request port and a Zbb execution unit.
// Sends one instruction at a time, waits for the result, and holds it on the writeback port.
module rvb_zbb32_issue #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_insn,
  input  logic [31:0] i_req_rs1,
  input  logic [31:0] i_req_rs2,
  output logic        o_fu_valid,
  input  logic        i_fu_ready,
  input  logic        i_fu_decoded,
  output logic [31:0] o_fu_insn,
  output logic [31:0] o_fu_rs1,
  output logic [31:0] o_fu_rs2,
  input  logic        i_fu_dout_valid,
  output logic        o_fu_dout_ready,
  input  logic [31:0] i_fu_rd,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_wb_illegal,
  output logic        o_wb_timeout,
  input  logic        i_cnt_clear,
  output logic [15:0] o_cnt_ops,
  output logic [15:0] o_cnt_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_fu_insn;
  logic [31:0] r_fu_rs1;
  logic [31:0] r_fu_rs2;
  logic [TW-1:0] r_tcnt;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        r_wb_illegal;
  logic        r_wb_timeout;
  logic [15:0] r_cnt [2];

  logic        w_accept;
  logic        w_finish;
  logic [31:0] w_fin_data;
  logic        w_fin_ill;
  logic        w_fin_to;
  logic        w_tcnt_inc;
  logic        w_wb_hs;
  logic [1:0]  w_cnt_inc;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_finish        = 1'b0;
    w_fin_data      = 32'd0;
    w_fin_ill       = 1'b0;
    w_fin_to        = 1'b0;
    w_tcnt_inc      = 1'b0;
    w_wb_hs         = 1'b0;
    o_req_ready     = 1'b0;
    o_fu_valid      = 1'b0;
    o_fu_dout_ready = 1'b0;
    o_wb_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Reset parks the FSM in IDLE, so ready is also gated by the reset input itself.
        o_req_ready = i_resetn;
        if (i_req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_fu_valid      = 1'b1;
        o_fu_dout_ready = 1'b1;
        if (!i_fu_decoded) begin
          w_finish     = 1'b1;
          w_fin_ill    = 1'b1;
          w_state_next = S_RESP;
        end else if (i_fu_ready && i_fu_dout_valid) begin
          w_finish     = 1'b1;
          w_fin_data   = i_fu_rd;
          w_state_next = S_RESP;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_finish     = 1'b1;
          w_fin_to     = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_tcnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        o_wb_valid  = 1'b1;
        o_req_ready = i_wb_ready;
        if (i_wb_ready) begin
          w_wb_hs = 1'b1;
          if (i_req_valid) begin
            w_accept     = 1'b1;
            w_state_next = S_ISSUE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_fu_insn <= 32'd0;
      r_fu_rs1  <= 32'd0;
      r_fu_rs2  <= 32'd0;
      r_tcnt    <= '0;
    end else if (w_accept) begin
      r_fu_insn <= i_req_insn;
      r_fu_rs1  <= i_req_rs1;
      r_fu_rs2  <= i_req_rs2;
      r_tcnt    <= '0;
    end else if (w_tcnt_inc) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // Result is frozen at the ISSUE->RESP transition; x0 destinations never carry data.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wb_addr    <= 5'd0;
      r_wb_data    <= 32'd0;
      r_wb_illegal <= 1'b0;
      r_wb_timeout <= 1'b0;
    end else if (w_finish) begin
      r_wb_addr    <= r_fu_insn[11:7];
      r_wb_data    <= (r_fu_insn[11:7] == 5'd0) ? 32'd0 : w_fin_data;
      r_wb_illegal <= w_fin_ill;
      r_wb_timeout <= w_fin_to;
    end
  end

  assign w_cnt_inc[0] = w_wb_hs & ~(r_wb_illegal | r_wb_timeout);
  assign w_cnt_inc[1] = w_wb_hs &  (r_wb_illegal | r_wb_timeout);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
          r_cnt[gi] <= 16'd0;
        end else if (i_cnt_clear) begin
          r_cnt[gi] <= 16'd0;
        end else if (w_cnt_inc[gi] && (r_cnt[gi] != 16'hFFFF)) begin
          r_cnt[gi] <= r_cnt[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign o_fu_insn    = r_fu_insn;
  assign o_fu_rs1     = r_fu_rs1;
  assign o_fu_rs2     = r_fu_rs2;
  assign o_wb_addr    = r_wb_addr;
  assign o_wb_data    = r_wb_data;
  assign o_wb_illegal = r_wb_illegal;
  assign o_wb_timeout = r_wb_timeout;
  assign o_cnt_ops    = r_cnt[0];
  assign o_cnt_err    = r_cnt[1];

endmodule

// File: tb/tb_rvb_zbb32_issue.sv
// Directed bench for rvb_zbb32_issue: expected writebacks queued at issue, checked by a monitor.
module tb_rvb_zbb32_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn, req_rs1, req_rs2;
  logic        fu_valid, fu_ready, fu_decoded, fu_dout_valid, fu_dout_ready;
  logic [31:0] fu_insn, fu_rs1, fu_rs2, fu_rd;
  logic        wb_valid, wb_ready, wb_illegal, wb_timeout;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cnt_clear;
  logic [15:0] cnt_ops, cnt_err;

  logic        unit_rdy;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        il;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] I_ANDN  = 32'h4020F1B3;
  localparam logic [31:0] I_ORN   = 32'h4020E2B3;
  localparam logic [31:0] I_XNOR  = 32'h4020C533;
  localparam logic [31:0] I_ANDN0 = 32'h4020F033;
  localparam logic [31:0] I_ADDI  = 32'h00000013;

  always #5 clk = ~clk;

  rvb_zbb32_issue #(.TIMEOUT(16)) dut (
    .i_clock(clk), .i_resetn(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_insn(req_insn), .i_req_rs1(req_rs1), .i_req_rs2(req_rs2),
    .o_fu_valid(fu_valid), .i_fu_ready(fu_ready), .i_fu_decoded(fu_decoded),
    .o_fu_insn(fu_insn), .o_fu_rs1(fu_rs1), .o_fu_rs2(fu_rs2),
    .i_fu_dout_valid(fu_dout_valid), .o_fu_dout_ready(fu_dout_ready), .i_fu_rd(fu_rd),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
    .o_wb_addr(wb_addr), .o_wb_data(wb_data),
    .o_wb_illegal(wb_illegal), .o_wb_timeout(wb_timeout),
    .i_cnt_clear(cnt_clear), .o_cnt_ops(cnt_ops), .o_cnt_err(cnt_err)
  );

  // Small Zbb unit model: decodes ANDN/ORN/XNOR only, answers combinationally when ready.
  assign fu_ready      = unit_rdy;
  assign fu_dout_valid = unit_rdy;
  assign fu_decoded    = (fu_insn[6:0] == 7'h33) && (fu_insn[31:25] == 7'h20) &&
                         ((fu_insn[14:12] == 3'd4) || (fu_insn[14:12] == 3'd6) ||
                          (fu_insn[14:12] == 3'd7));
  always_comb begin
    fu_rd = 32'd0;
    case (fu_insn[14:12])
      3'd7:    fu_rd = fu_rs1 & ~fu_rs2;
      3'd6:    fu_rd = fu_rs1 | ~fu_rs2;
      3'd4:    fu_rd = ~(fu_rs1 ^ fu_rs2);
      default: fu_rd = 32'd0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h expected no writeback", wb_addr, wb_data);
      end else begin
        mon_e = sb_q.pop_front();
        $display("wb: addr=%0d data=%h illegal=%0b timeout=%0b", wb_addr, wb_data, wb_illegal, wb_timeout);
        chk("wb_addr",    {27'd0, wb_addr},    {27'd0, mon_e.a});
        chk("wb_data",    wb_data,             mon_e.d);
        chk("wb_illegal", {31'd0, wb_illegal}, {31'd0, mon_e.il});
        chk("wb_timeout", {31'd0, wb_timeout}, {31'd0, mon_e.to});
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    bit ok;
    ok = 1'b0;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("req_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_wb_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wb_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wb_valid_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_wb_done();
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wb_valid) seen = 1'b1;
      else if (seen) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wb_done", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] a, input logic [31:0] d, input logic il, input logic to);
    exp_t e;
    e = '{a: a, d: d, il: il, to: to};
    sb_q.push_back(e);
    issue(insn, rs1, rs2);
    wait_wb_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_insn  = 32'd0;
    req_rs1   = 32'd0;
    req_rs2   = 32'd0;
    wb_ready  = 1'b1;
    cnt_clear = 1'b0;
    unit_rdy  = 1'b1;

    #3;
    chk("rst_req_ready",  {31'd0, req_ready},     32'd0);
    chk("rst_fu_valid",   {31'd0, fu_valid},      32'd0);
    chk("rst_dout_ready", {31'd0, fu_dout_ready}, 32'd0);
    chk("rst_wb_valid",   {31'd0, wb_valid},      32'd0);
    chk("rst_fu_insn",    fu_insn,                32'd0);
    chk("rst_wb_data",    wb_data,                32'd0);
    chk("rst_cnt_ops",    {16'd0, cnt_ops},       32'd0);
    #20;
    rst_n = 1'b1;
    #1;
    chk("first_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // ANDN with exact latency checks
    e = '{a: 5'd3, d: 32'hF000F000, il: 1'b0, to: 1'b0};
    sb_q.push_back(e);
    issue(I_ANDN, 32'hFF00FF00, 32'h0F0F0F0F);
    chk("andn_fu_valid_n1", {31'd0, fu_valid}, 32'd1);
    chk("andn_fu_insn",     fu_insn,           I_ANDN);
    chk("andn_fu_rs1",      fu_rs1,            32'hFF00FF00);
    chk("andn_fu_rs2",      fu_rs2,            32'h0F0F0F0F);
    chk("andn_wb_valid_n1", {31'd0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    chk("andn_wb_valid_n2", {31'd0, wb_valid}, 32'd1);
    chk("andn_fu_valid_n2", {31'd0, fu_valid}, 32'd0);
    chk("andn_fu_hold",     fu_insn,           I_ANDN);
    @(posedge clk); #1;
    chk("andn_cnt_ops", {16'd0, cnt_ops}, 32'd1);

    // Illegal instruction: single ISSUE cycle
    e = '{a: 5'd0, d: 32'd0, il: 1'b1, to: 1'b0};
    sb_q.push_back(e);
    issue(I_ADDI, 32'h11111111, 32'h22222222);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_valid) break;
      if (fu_valid) n++;
      @(posedge clk); #1;
    end
    chk("illegal_issue_cycles", n, 32'd1);
    wait_wb_done();
    chk("illegal_cnt_err", {16'd0, cnt_err}, 32'd1);
    chk("illegal_cnt_ops", {16'd0, cnt_ops}, 32'd1);

    // Timeout: unit never ready
    unit_rdy = 1'b0;
    e = '{a: 5'd3, d: 32'd0, il: 1'b0, to: 1'b1};
    sb_q.push_back(e);
    issue(I_ANDN, 32'hFF00FF00, 32'h0F0F0F0F);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_valid) break;
      if (fu_valid) n++;
      @(posedge clk); #1;
    end
    chk("timeout_issue_cycles", n, 32'd16);
    wait_wb_done();
    unit_rdy = 1'b1;
    chk("timeout_cnt_err", {16'd0, cnt_err}, 32'd2);

    run_op(I_ORN,   32'h12340000, 32'hFFFF0F0F, 5'd5,  32'h1234F0F0, 1'b0, 1'b0);
    run_op(I_XNOR,  32'hAAAA5555, 32'hAAAAAAAA, 5'd10, 32'hFFFF0000, 1'b0, 1'b0);
    run_op(I_ANDN0, 32'hFFFFFFFF, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b0);
    chk("mix_cnt_ops", {16'd0, cnt_ops}, 32'd4);
    chk("mix_cnt_err", {16'd0, cnt_err}, 32'd2);

    // Backpressure then back-to-back acceptance
    wb_ready = 1'b0;
    e = '{a: 5'd3, d: 32'hF000F000, il: 1'b0, to: 1'b0};
    sb_q.push_back(e);
    e = '{a: 5'd5, d: 32'h1234F0F0, il: 1'b0, to: 1'b0};
    sb_q.push_back(e);
    issue(I_ANDN, 32'hFF00FF00, 32'h0F0F0F0F);
    wait_wb_valid();
    req_insn  = I_ORN;
    req_rs1   = 32'h12340000;
    req_rs2   = 32'hFFFF0F0F;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_wb_valid",  {31'd0, wb_valid},  32'd1);
      chk("bp_wb_addr",   {27'd0, wb_addr},   32'd3);
      chk("bp_wb_data",   wb_data,            32'hF000F000);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    #1;
    chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_fu_valid", {31'd0, fu_valid}, 32'd1);
    chk("b2b_fu_insn",  fu_insn,           I_ORN);
    chk("b2b_wb_valid", {31'd0, wb_valid}, 32'd0);
    wait_wb_done();
    chk("b2b_cnt_ops", {16'd0, cnt_ops}, 32'd6);

    // Asynchronous reset pulse while in ISSUE
    unit_rdy = 1'b0;
    issue(I_XNOR, 32'h0000FFFF, 32'h12345678);
    @(posedge clk); #1;
    chk("pre_rst_in_issue", {31'd0, fu_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fu_valid",   {31'd0, fu_valid},      32'd0);
    chk("arst_dout_ready", {31'd0, fu_dout_ready}, 32'd0);
    chk("arst_req_ready",  {31'd0, req_ready},     32'd0);
    chk("arst_wb_valid",   {31'd0, wb_valid},      32'd0);
    chk("arst_fu_insn",    fu_insn,                32'd0);
    chk("arst_fu_rs1",     fu_rs1,                 32'd0);
    chk("arst_wb_data",    wb_data,                32'd0);
    chk("arst_flags",      {30'd0, wb_illegal, wb_timeout}, 32'd0);
    chk("arst_cnt_ops",    {16'd0, cnt_ops},       32'd0);
    chk("arst_cnt_err",    {16'd0, cnt_err},       32'd0);
    #2;
    rst_n = 1'b1;
    unit_rdy = 1'b1;
    #1;
    chk("arst_after_req_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("arst_no_wb", {31'd0, wb_valid}, 32'd0);
    end

    // cnt_clear in the same cycle as a counted handshake
    wb_ready = 1'b0;
    e = '{a: 5'd3, d: 32'hF000F000, il: 1'b0, to: 1'b0};
    sb_q.push_back(e);
    issue(I_ANDN, 32'hFF00FF00, 32'h0F0F0F0F);
    wait_wb_valid();
    wb_ready  = 1'b1;
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    chk("clr_win_ops",  {16'd0, cnt_ops},  32'd0);
    chk("clr_win_err",  {16'd0, cnt_err},  32'd0);
    chk("clr_wb_valid", {31'd0, wb_valid}, 32'd0);
    run_op(I_XNOR, 32'hAAAA5555, 32'hAAAAAAAA, 5'd10, 32'hFFFF0000, 1'b0, 1'b0);
    chk("post_clr_ops", {16'd0, cnt_ops}, 32'd1);
    run_op(I_ADDI, 32'h0, 32'h0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("post_clr_err", {16'd0, cnt_err}, 32'd1);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
